// File: rtl/ahb_dma_copy_if.sv
// AHB-Lite bus bundle between the copy engine (master) and memory (slave).
interface ahb_dma_copy_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_dma_copy.sv
// Word-by-word memory copy engine on an AHB-Lite master port.
// Each word is a single read followed by a single write; the write address
// phase overlaps the read data phase and the next read address overlaps the
// write data phase, giving two cycles per word with zero-wait slaves.
module ahb_dma_copy #(
    parameter int unsigned LW = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            start_i,
    input  logic [31:0]     src_i,
    input  logic [31:0]     dst_i,
    input  logic [LW-1:0]   len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    ahb_dma_copy_if.master  ahb
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] SIZE_WORD    = 3'b010;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [3:0] PROT_DATA    = 4'b0011;
    localparam logic [AW-1:0] WORD_STEP = AW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RA,
        S_RDWA,
        S_WDRA,
        S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   wbuf_q, wbuf_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [1:0]      htrans_c;
    logic [AW-1:0]   haddr_c;
    logic            hwrite_c;

    // Byte-lane bits of the start addresses are deliberately discarded.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_i[1:0], dst_i[1:0]};

    // State, pointers, count, word buffer and status flags.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wbuf_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            wbuf_q  <= wbuf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and bus address-phase controls; an error response cancels
    // the pending address in its first cycle, so HTRANS depends on HRESP.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        wbuf_d   = wbuf_q;
        done_d   = 1'b0;
        err_d    = err_q;
        htrans_c = TRANS_IDLE;
        haddr_c  = '0;
        hwrite_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = {src_i[31:2], 2'b00};
                        dst_d   = {dst_i[31:2], 2'b00};
                        cnt_d   = len_i;
                        state_d = S_RA;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_RA: begin
                htrans_c = TRANS_NONSEQ;
                haddr_c  = src_q;
                if (ahb.HREADY) begin
                    state_d = S_RDWA;
                end
            end

            S_RDWA: begin
                if (ahb.HRESP) begin
                    if (ahb.HREADY) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    htrans_c = TRANS_NONSEQ;
                    haddr_c  = dst_q;
                    hwrite_c = 1'b1;
                    if (ahb.HREADY) begin
                        wbuf_d  = ahb.HRDATA;
                        state_d = S_WDRA;
                    end
                end
            end

            S_WDRA: begin
                if (ahb.HRESP) begin
                    if (ahb.HREADY) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    if (cnt_q > LW'(1)) begin
                        htrans_c = TRANS_NONSEQ;
                        haddr_c  = src_q + WORD_STEP;
                    end
                    if (ahb.HREADY) begin
                        src_d = src_q + WORD_STEP;
                        dst_d = dst_q + WORD_STEP;
                        cnt_d = cnt_q - LW'(1);
                        if (cnt_q > LW'(1)) begin
                            state_d = S_RDWA;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            S_ERR: begin
                if (ahb.HREADY) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ahb.HTRANS = htrans_c;
    assign ahb.HADDR  = haddr_c;
    assign ahb.HWRITE = hwrite_c;
    assign ahb.HWDATA = wbuf_q;
    assign ahb.HSIZE  = SIZE_WORD;
    assign ahb.HBURST = BURST_SINGLE;
    assign ahb.HPROT  = PROT_DATA;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign err_o  = err_q;
endmodule

// File: tb/tb_ahb_dma_copy.sv
// Directed bench for ahb_dma_copy with a small AHB-Lite memory slave model.
module tb_ahb_dma_copy;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start_i;
    logic [31:0] src_i;
    logic [31:0] dst_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 HCLK = ~HCLK;

    ahb_dma_copy_if bus ();

    ahb_dma_copy #(.LW(16)) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .start_i (start_i),
        .src_i   (src_i),
        .dst_i   (dst_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .ahb     (bus.master)
    );

    localparam logic [31:0] WA = 32'hA1B2C3D4;
    localparam logic [31:0] WB = 32'h0BADF00D;
    localparam logic [31:0] WC = 32'hC0FFEE01;
    localparam logic [31:0] WH = 32'hFEEDFACE;
    localparam logic [31:0] WZ = 32'h01234567;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory slave: 1024 words aliased on addr[11:2]; optional read wait/error.
    logic [31:0] mem [0:1023];
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;
    int          dp_wait, dp_err;
    logic        wait_en, err_en;
    logic [31:0] wait_addr, err_addr;
    int          wait_n;

    always_comb begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        if (dp_valid) begin
            if (dp_err == 1) begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b1;
            end else if (dp_err == 2) begin
                bus.HRESP = 1'b1;
            end else if (dp_wait > 0) begin
                bus.HREADY = 1'b0;
            end else if (!dp_write) begin
                bus.HRDATA = mem[dp_addr[11:2]];
            end
        end
    end

    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 32'h0;
            dp_wait  <= 0;
            dp_err   <= 0;
        end else if (bus.HREADY) begin
            if (dp_valid && dp_write && !bus.HRESP) mem[dp_addr[11:2]] <= bus.HWDATA;
            dp_err  <= 0;
            dp_wait <= 0;
            if (bus.HTRANS == 2'b10) begin
                dp_valid <= 1'b1;
                dp_write <= bus.HWRITE;
                dp_addr  <= bus.HADDR;
                if (!bus.HWRITE && wait_en && bus.HADDR == wait_addr) dp_wait <= wait_n;
                if (!bus.HWRITE && err_en && bus.HADDR == err_addr) dp_err <= 1;
            end else begin
                dp_valid <= 1'b0;
            end
        end else begin
            if (dp_err == 1) dp_err <= 2;
            else if (dp_wait > 0) dp_wait <= dp_wait - 1;
        end
    end

    // Observations collected by run_copy.
    int          r_done_cyc, r_done_cnt, r_busy_cnt, r_stab_viol, r_err_cyc, r_err_bad;
    logic [31:0] r_ns_mask;
    logic [31:0] r_st_addr;
    logic [1:0]  r_st_trans;
    logic        r_st_write;

    // Start a copy at edge 0, then watch the bus once per cycle (#1 after each edge).
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int inj_cyc);
        logic        prev_stall;
        logic [66:0] prev_bus;
        logic        stall;
        @(negedge HCLK);
        start_i = 1'b1; src_i = s; dst_i = d; len_i = n;
        @(posedge HCLK); #1;
        start_i = 1'b0;
        r_done_cyc = -1; r_done_cnt = 0; r_busy_cnt = 0; r_stab_viol = 0;
        r_err_cyc = 0; r_err_bad = 0; r_ns_mask = 32'h0;
        r_st_addr = 32'h0; r_st_trans = 2'b00; r_st_write = 1'b0;
        prev_stall = 1'b0; prev_bus = '0;
        for (int c = 0; c < 40; c++) begin
            if (c == inj_cyc) begin
                start_i = 1'b1; src_i = 32'h200; dst_i = 32'h380; len_i = 16'd5;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                if (r_done_cnt == 0) r_done_cyc = c;
                r_done_cnt++;
            end
            if (busy_o) r_busy_cnt++;
            if (bus.HTRANS == 2'b10 && c < 32) r_ns_mask[c] = 1'b1;
            if (bus.HRESP && !bus.HREADY) begin
                r_err_cyc++;
                if (bus.HTRANS != 2'b00) r_err_bad++;
            end
            if (prev_stall && prev_bus != {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HWDATA})
                r_stab_viol++;
            stall = !bus.HREADY && !bus.HRESP;
            if (stall) begin
                r_st_addr = bus.HADDR; r_st_trans = bus.HTRANS; r_st_write = bus.HWRITE;
            end
            prev_stall = stall;
            prev_bus   = {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HWDATA};
            if (r_done_cnt > 0 && c >= r_done_cyc + 3) break;
            @(posedge HCLK); #1;
        end
        start_i = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; start_i = 1'b0; src_i = 32'h0; dst_i = 32'h0; len_i = 16'd0;
        wait_en = 1'b0; err_en = 1'b0; wait_addr = 32'h0; err_addr = 32'h0; wait_n = 0;
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A5A0000 + 32'(i);
        #1;
        mem[64] <= WA; mem[65] <= WB; mem[66] <= WC;
        mem[1023] <= WH; mem[0] <= WZ;

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rst_haddr",  bus.HADDR,        32'h0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst_hwdata", bus.HWDATA,       32'h0);
        chk("rst_busy",   32'(busy_o),     32'h0);
        chk("rst_done",   32'(done_o),     32'h0);
        chk("rst_err",    32'(err_o),      32'h0);
        chk("const_hsize",  32'(bus.HSIZE),  32'h2);
        chk("const_hburst", 32'(bus.HBURST), 32'h0);
        chk("const_hprot",  32'(bus.HPROT),  32'h3);
        @(negedge HCLK);
        HRESET = 1'b0;

        // Zero-wait copy of three words
        run_copy(32'h100, 32'h200, 16'd3, -1);
        chk("zw_w0", mem[128], WA);
        chk("zw_w1", mem[129], WB);
        chk("zw_w2", mem[130], WC);
        chk("zw_nonseq_cycles", r_ns_mask, 32'h0000003F);
        chk("zw_done_cyc", 32'(r_done_cyc), 32'd7);
        chk("zw_done_cnt", 32'(r_done_cnt), 32'd1);
        chk("zw_err", 32'(err_o), 32'h0);
        chk("zw_busy_end", 32'(busy_o), 32'h0);

        // Two read wait states on word 0
        wait_en = 1'b1; wait_addr = 32'h100; wait_n = 2;
        run_copy(32'h100, 32'h300, 16'd3, -1);
        wait_en = 1'b0;
        chk("ws_w0", mem[192], WA);
        chk("ws_w1", mem[193], WB);
        chk("ws_w2", mem[194], WC);
        chk("ws_done_cyc", 32'(r_done_cyc), 32'd9);
        chk("ws_stable", 32'(r_stab_viol), 32'd0);
        chk("ws_stall_haddr", r_st_addr, 32'h300);
        chk("ws_stall_htrans", 32'(r_st_trans), 32'h2);
        chk("ws_stall_hwrite", 32'(r_st_write), 32'h1);

        // Error response on the read of 0x104
        err_en = 1'b1; err_addr = 32'h104;
        run_copy(32'h100, 32'h220, 16'd3, -1);
        err_en = 1'b0;
        chk("re_err_cycles", 32'(r_err_cyc), 32'd1);
        chk("re_htrans_in_err", 32'(r_err_bad), 32'd0);
        chk("re_w0", mem[136], WA);
        chk("re_no_w1", mem[137], 32'h5A5A0089);
        chk("re_no_w2", mem[138], 32'h5A5A008A);
        chk("re_err", 32'(err_o), 32'h1);
        chk("re_done_cyc", 32'(r_done_cyc), 32'd5);
        chk("re_done_cnt", 32'(r_done_cnt), 32'd1);

        // Zero-length request (also clears the sticky error)
        run_copy(32'h100, 32'h2A0, 16'd0, -1);
        chk("zl_nonseq", r_ns_mask, 32'h0);
        chk("zl_done_cyc", 32'(r_done_cyc), 32'd0);
        chk("zl_done_cnt", 32'(r_done_cnt), 32'd1);
        chk("zl_busy", 32'(r_busy_cnt), 32'd0);
        chk("zl_err_clr", 32'(err_o), 32'h0);
        chk("zl_no_write", mem[168], 32'h5A5A00A8);

        // Start while busy is ignored
        run_copy(32'h100, 32'h340, 16'd3, 2);
        chk("sb_w0", mem[208], WA);
        chk("sb_w1", mem[209], WB);
        chk("sb_w2", mem[210], WC);
        chk("sb_no_w3", mem[211], 32'h5A5A00D3);
        chk("sb_no_new_dst", mem[224], 32'h5A5A00E0);
        chk("sb_done_cyc", 32'(r_done_cyc), 32'd7);
        chk("sb_done_cnt", 32'(r_done_cnt), 32'd1);

        // Reset asserted during RDWA
        @(negedge HCLK);
        start_i = 1'b1; src_i = 32'h100; dst_i = 32'h260; len_i = 16'd3;
        @(posedge HCLK); #1;
        start_i = 1'b0;
        @(posedge HCLK); #1;
        chk("rm_in_rdwa", 32'(bus.HWRITE), 32'h1);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        chk("rm_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rm_busy", 32'(busy_o), 32'h0);
        chk("rm_err", 32'(err_o), 32'h0);
        chk("rm_haddr", bus.HADDR, 32'h0);
        chk("rm_no_write", mem[152], 32'h5A5A0098);
        run_copy(32'h100, 32'h240, 16'd2, -1);
        chk("rm_after_w0", mem[144], WA);
        chk("rm_after_w1", mem[145], WB);
        chk("rm_after_done_cyc", 32'(r_done_cyc), 32'd5);

        // Pointer wrap at the top of the address space, low bits ignored
        run_copy(32'hFFFFFFFE, 32'h281, 16'd2, -1);
        chk("wr_w0", mem[160], WH);
        chk("wr_w1", mem[161], WZ);
        chk("wr_done_cyc", 32'(r_done_cyc), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_dma_copy.md
AHB_DMA_COPY -- requirements
Module: ahb_dma_copy

Interface
REQ-001 SHALL have parameter LW, default 16, giving the word-count width of len_i.
REQ-002 SHALL have port HCLK  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port HRESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  pulse requesting a copy; sampled only when busy_o=0.
REQ-005 SHALL have ports src_i / dst_i  input  32 / 32  byte addresses of source and destination; bits [1:0] are ignored and treated as 00.
REQ-006 SHALL have port len_i  input  LW  number of 32-bit words to copy.
REQ-007 SHALL have port busy_o  output  1  high from the cycle after an accepted start through the last data phase.
REQ-008 SHALL have port done_o  output  1  one-cycle completion pulse, for success or error.
REQ-009 SHALL have port err_o  output  1  sticky error flag; cleared by an accepted start or by reset.
REQ-010 SHALL have AHB-Lite master ports, all outputs: HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HWDATA 32.
REQ-011 SHALL have AHB-Lite master ports, all inputs: HRDATA 32, HREADY 1, HRESP 1.

Function
REQ-012 SHALL drive HSIZE=010 (word), HBURST=000 (SINGLE) and HPROT=0011 constantly; each transfer SHALL be NONSEQ (10) or IDLE (00), never BUSY or SEQ.
REQ-013 SHALL implement FSM states IDLE, RA, RDWA, WDRA and ERR.
- IDLE: HTRANS=IDLE.
- RA: read address phase only.
- RDWA: read data phase plus write address phase.
- WDRA: write data phase plus, if words remain, the next read address phase.
- ERR: second cycle of an error response.
REQ-014 In IDLE, start_i=1 with len_i!=0 SHALL latch the pointers (src_i, dst_i with [1:0] forced to 00) and count=len_i, clear err_o, and move to RA.
REQ-015 In IDLE, start_i=1 with len_i=0 SHALL clear err_o, issue no AHB transfer, and pulse done_o in the next cycle.
REQ-016 RA SHALL drive HTRANS=NONSEQ, HADDR=src pointer, HWRITE=0, and SHALL go to RDWA on HREADY=1.
REQ-017 RDWA SHALL drive HTRANS=NONSEQ, HADDR=dst pointer, HWRITE=1.
- On HREADY=1 with HRESP=0: capture HRDATA into the word buffer and go to WDRA.
REQ-018 WDRA SHALL drive HWDATA=word buffer throughout the data phase.
- If count>1: also drive HTRANS=NONSEQ, HADDR=src pointer+4, HWRITE=0.
- If count=1: drive HTRANS=IDLE.
REQ-019 WDRA completion (HREADY=1, HRESP=0) SHALL add 4 to both pointers and decrement count.
- count was >1: go to RDWA.
- count was 1: go to IDLE and pulse done_o.
REQ-020 While HREADY=0 without an error, HADDR, HTRANS, HWRITE and HWDATA SHALL stay stable and no state, pointer or count SHALL change.
REQ-021 Pointer addition SHALL be 32-bit modulo, so 0xFFFFFFFC+4 wraps to 0x00000000 with no special handling.
REQ-022 Throughput SHALL be 2 cycles per word with zero-wait slaves.
- The last WDRA completes on edge 2N+1 after the start-sampling edge (edge 0).
- done_o is high in the following cycle, edge 2N+1 to 2N+2.
REQ-023 In a data phase that receives HRESP=1 with HREADY=0 (first error cycle), the FSM SHALL drive HTRANS=IDLE in that same cycle, cancelling any pending address, and move to ERR.
REQ-024 ERR SHALL hold HTRANS=IDLE and, on HREADY=1, go to IDLE, set err_o and pulse done_o.
REQ-025 A read error SHALL prevent the corresponding write; a write error SHALL cancel the next read; pointers and count SHALL not advance for the failing word.
REQ-026 start_i SHALL be ignored while busy_o=1.
REQ-027 busy_o SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-028 When HRESET=1 at a clock edge, the FSM SHALL go to IDLE with:
- HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0;
- busy_o=0, done_o=0, err_o=0;
- pointers, count and word buffer cleared;
- any in-flight transfer abandoned.
REQ-029 Reset SHALL take priority over every other event in the same cycle, including start_i.

Verification
REQ-030 Bench SHALL cover a zero-wait copy:
- Stimulus: src=0x100, dst=0x200, len=3; memory 0x100..0x108 = A,B,C.
- Required: writes 0x200=A, 0x204=B, 0x208=C; HTRANS NONSEQ on edges 0..5; done_o high in cycle 7-8; err_o=0.
REQ-031 Bench SHALL cover read wait states:
- Stimulus: HREADY=0 for 2 cycles in the read data phase of word 0.
- Required: HADDR=dst, HWRITE=1 and HTRANS=10 held stable; correct data written; done_o 2 cycles later than in REQ-030.
REQ-032 Bench SHALL cover a read error:
- Stimulus: len=3; two-cycle ERROR on the read of 0x104.
- Required: HTRANS=00 in the first error cycle; no write to 0x204; err_o=1 with done_o pulse; 0x200=A only.
REQ-033 Bench SHALL cover a zero-length request:
- Stimulus: len=0 with start.
- Required: no NONSEQ ever; done_o pulse next cycle; busy_o stays 0.
REQ-034 Bench SHALL cover reset mid-copy:
- Stimulus: HRESET pulsed during RDWA.
- Required: next cycle HTRANS=00, busy_o=0, err_o=0; a later start copies correctly.
REQ-035 Bench SHALL cover start while busy:
- Stimulus: start_i with new src/dst/len mid-copy.
- Required: ignored; the original copy completes unchanged with exactly one done_o pulse.
